stopwatch_bcd_counter: RTL and testbench

//  Four-digit BCD stopwatch core (SS.hh, 00.00..59.99) driven from the board clock and push-buttons.

---
 rtl/stopwatch_bcd_counter_pkg.sv | 11 +
 rtl/stopwatch_bcd_counter_bcd_digit.sv | 33 +++
 rtl/stopwatch_bcd_counter.sv | 124 ++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared constants for the BCD stopwatch: digit width, digit limits and
// the default 10 ms prescaler division for a 50 MHz board clock.
package stopwatch_pkg;

  localparam int              BCD_W            = 4;
  localparam int              NUM_DIGITS       = 4;
  localparam logic [BCD_W-1:0] DIG_MAX_UNITS   = 4'd9;
  localparam logic [BCD_W-1:0] DIG_MAX_TENS    = 4'd5;
  localparam int              TICK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One BCD digit of the stopwatch carry chain. Counts 0..MAX on inc and
// wraps to 0, raising carry combinationally in the same cycle so every
// digit of the chain updates on the same clock edge.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIG_MAX_UNITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_reg;
  logic             at_max;

  assign at_max = (q_reg == MAX);
  assign carry  = inc & at_max;
  assign q      = q_reg;

  // Digit register: reset and clear dominate, otherwise roll MAX -> 0 on inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= '0;
    end else if (inc) begin
      q_reg <= at_max ? '0 : q_reg + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch core (SS.hh). Synchronises the two push-buttons,
// turns their falling edges into one-cycle presses, runs the 10 ms
// prescaler while counting and drives a chain of four bcd_digit counters.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [1:0]       KEY,
  output logic [BCD_W-1:0] DIG0,
  output logic [BCD_W-1:0] DIG1,
  output logic [BCD_W-1:0] DIG2,
  output logic [BCD_W-1:0] DIG3,
  output logic             running,
  output logic             wrap
);

  localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]       sync_reg [SYNC_STAGES];
  logic [1:0]       synced;
  logic [1:0]       hist_reg;
  logic [1:0]       press_reg;
  logic             clear;
  logic             toggle;
  logic             running_reg;
  logic [PW-1:0]    presc_reg;
  logic             tick;
  logic             wrap_reg;
  logic [NUM_DIGITS:0] chain;
  logic [BCD_W-1:0] dig [NUM_DIGITS];

  // Button synchronisers: reset loads the released level (1) so leaving
  // reset never looks like a falling edge.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          sync_reg[gi] <= 2'b11;
        end else if (gi == 0) begin
          sync_reg[gi] <= KEY;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign synced = sync_reg[SYNC_STAGES-1];

  // Edge detect: history flop plus a registered one-cycle press per falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hist_reg  <= 2'b11;
      press_reg <= 2'b00;
    end else begin
      hist_reg  <= synced;
      press_reg <= hist_reg & ~synced;
    end
  end

  // Clear beats start/stop when both buttons fire together.
  assign clear  = press_reg[1];
  assign toggle = press_reg[0] & ~press_reg[1];

  // Run flag: clear forces stop, start/stop press toggles.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      running_reg <= 1'b0;
    end else if (toggle) begin
      running_reg <= ~running_reg;
    end
  end

  assign tick = running_reg & (presc_reg == PRESC_LAST);

  // Prescaler: advances only while running and holds when stopped, so a
  // resume finishes the partially elapsed tick.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      presc_reg <= '0;
    end else if (running_reg) begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end
  end

  // Carry chain: each digit increments on the carry of the one below.
  assign chain[0] = tick;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit #(
        .MAX ((gi == NUM_DIGITS - 1) ? DIG_MAX_TENS : DIG_MAX_UNITS)
      ) u_digit (
        .clk   (CLOCK_50),
        .rst   (reset),
        .clr   (clear),
        .inc   (chain[gi]),
        .q     (dig[gi]),
        .carry (chain[gi+1])
      );
    end
  endgenerate

  // Wrap pulse: carry out of the tens-of-seconds digit, suppressed by clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= chain[NUM_DIGITS] & ~clear;
    end
  end

  assign DIG0    = dig[0];
  assign DIG1    = dig[1];
  assign DIG2    = dig[2];
  assign DIG3    = dig[3];
  assign running = running_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for the stopwatch: a stimulus process steps a
// time-in-hundredths reference model and queues the expected outputs for
// every clock edge; a monitor on the falling edge pops and compares.
module tb_stopwatch_bcd_counter;

  localparam int TICK_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [1:0] KEY      = 2'b11;
  logic [3:0] DIG0, DIG1, DIG2, DIG3;
  logic       running, wrap;

  always #5 CLOCK_50 = ~CLOCK_50;

  stopwatch_bcd_counter #(
    .TICK_DIV    (TICK_DIV),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .KEY      (KEY),
    .DIG0     (DIG0),
    .DIG1     (DIG1),
    .DIG2     (DIG2),
    .DIG3     (DIG3),
    .running  (running),
    .wrap     (wrap)
  );

  typedef struct packed {
    logic [15:0] digs;
    logic        run;
    logic        wrp;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: elapsed time in hundredths, phase within the current
  // 10 ms tick, run flag, and the last four KEY samples taken at clock edges.
  int         m_time  = 0;
  int         m_phase = 0;
  bit         m_run   = 0;
  bit         m_wrap  = 0;
  logic [1:0] m_samp [4];

  function automatic obs_t model_obs();
    obs_t o;
    o.digs = {4'(m_time / 1000), 4'((m_time / 100) % 10),
              4'((m_time / 10) % 10), 4'(m_time % 10)};
    o.run  = m_run;
    o.wrp  = m_wrap;
    return o;
  endfunction

  // A press takes effect on the fourth edge after the button is first sampled low.
  task automatic model_edge(input logic r, input logic [1:0] k);
    logic [1:0] pr;
    bit         tk;
    if (r) begin
      m_time = 0; m_phase = 0; m_run = 0; m_wrap = 0;
      for (int i = 0; i < 4; i++) m_samp[i] = 2'b11;
      return;
    end
    pr = m_samp[3] & ~m_samp[2];
    tk = m_run && (m_phase == TICK_DIV - 1);
    if (pr[1]) begin
      m_time = 0; m_phase = 0; m_run = 0; m_wrap = 0;
    end else begin
      m_wrap = tk && (m_time == 5999);
      if (tk) m_time = (m_time + 1) % 6000;
      if (m_run) m_phase = (m_phase + 1) % TICK_DIV;
      if (pr[0]) m_run = !m_run;
    end
    m_samp[3] = m_samp[2];
    m_samp[2] = m_samp[1];
    m_samp[1] = m_samp[0];
    m_samp[0] = k;
  endtask

  task automatic cycle(input logic r, input logic [1:0] k);
    reset = r;
    KEY   = k;
    @(posedge CLOCK_50);
    model_edge(r, k);
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b11);
  endtask

  task automatic press(input logic [1:0] k, input string what);
    $display("txn %0t: press %s KEY=%b at %0d.%02d run=%0b", $time, what, k,
             m_time / 100, m_time % 100, m_run);
    for (int i = 0; i < 3; i++) cycle(1'b0, k);
    cycle(1'b0, 2'b11);
  endtask

  task automatic check_budget(input int budget, input string what);
    n_checks++;
    if (budget <= 0) begin
      n_fail++;
      $display("FAIL timeout_%s: budget left %0d, required > 0", what, budget);
    end
  endtask

  // Monitor: one comparison per clock edge, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {DIG3, DIG2, DIG1, DIG0, running, wrap};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL edge_check t=%0t: got %h.%h run=%b wrap=%b, required %h.%h run=%b wrap=%b",
                   $time, mon_act.digs[15:8], mon_act.digs[7:0], mon_act.run, mon_act.wrp,
                   mon_exp.digs[15:8], mon_exp.digs[7:0], mon_exp.run, mon_exp.wrp);
      end
    end
  end

  initial begin
    int         budget;
    int         len;
    logic [1:0] rk;
    bit         rr;

    for (int i = 0; i < 4; i++) m_samp[i] = 2'b11;

    // Reset for two cycles, then confirm no press appears on release.
    $display("txn %0t: reset", $time);
    cycle(1'b1, 2'b11);
    cycle(1'b1, 2'b11);
    idle(8);

    // Start: KEY[0] low for five cycles, then 40 more cycles.
    $display("txn %0t: start", $time);
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'b10);
    idle(40);

    // Run through 09.99->10.00 and on to the 59.99 wrap.
    $display("txn %0t: run to wrap", $time);
    budget = 30000;
    while (!m_wrap && budget > 0) begin
      cycle(1'b0, 2'b11);
      budget--;
    end
    check_budget(budget, "wrap");
    idle(10);

    // Stop with the prescaler held at 2, wait, resume.
    budget = 100;
    while (!(m_run && m_phase == 2) && budget > 0) begin
      cycle(1'b0, 2'b11);
      budget--;
    end
    check_budget(budget, "phase2");
    press(2'b10, "stop");
    idle(100);
    press(2'b10, "resume");
    idle(20);

    // Reset mid-count at 37.42.
    budget = 20000;
    while (!(m_run && m_time == 3742) && budget > 0) begin
      cycle(1'b0, 2'b11);
      budget--;
    end
    check_budget(budget, "t3742");
    $display("txn %0t: reset at 37.42", $time);
    cycle(1'b1, 2'b11);
    idle(10);

    // Both buttons together while running: clear wins.
    press(2'b10, "start");
    idle(57);
    press(2'b00, "both");
    idle(10);

    // Both buttons together on the 59.99 tick: clear wins, no wrap.
    press(2'b10, "start");
    budget = 30000;
    while (!(m_run && m_time == 5999 && m_phase == 0) && budget > 0) begin
      cycle(1'b0, 2'b11);
      budget--;
    end
    check_budget(budget, "t5999");
    press(2'b00, "both on tick");
    idle(10);

    // Randomised buttons with occasional resets.
    $display("txn %0t: random phase", $time);
    for (int i = 0; i < 3000; i += len) begin
      rk  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      rr  = ($urandom_range(0, 199) == 0);
      for (int j = 0; j < len; j++) cycle(rr && (j == 0), rk);
    end
    idle(5);

    @(negedge CLOCK_50);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
